// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register: a 2-entry skid buffer behind a valid/ready handshake.
// Optional EX-stage bypass outputs are enabled by defining EXMEM_FWD_EN.
module ex_mem_skid_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RD_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             ex_valid_i,
   output logic             ex_ready_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic [WIDTH-1:0] store_data_i,
   input  logic [RD_W-1:0]  rd_i,
   input  logic             reg_write_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [2:0]       funct3_i,
   output logic             mem_valid_o,
   input  logic             mem_ready_i,
   output logic [WIDTH-1:0] alu_result_o,
   output logic [WIDTH-1:0] store_data_o,
   output logic [RD_W-1:0]  rd_o,
   output logic             reg_write_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic [2:0]       funct3_o
`ifdef EXMEM_FWD_EN
   ,
   output logic             fwd_valid_o,
   output logic [RD_W-1:0]  fwd_rd_o,
   output logic [WIDTH-1:0] fwd_data_o
`endif
);

   localparam int unsigned F3_W    = 3;
   localparam int unsigned ENTRY_W = 2 * WIDTH + RD_W + 3 + F3_W;

   // State encoding is {main_v, skid_v}, so the valid bits are plain flop outputs.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_e;

   state_e state_q, state_d;

   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] main_q;
   logic [ENTRY_W-1:0] skid_q;

   logic main_v;
   logic skid_v;
   logic accept;
   logic pop;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   logic [WIDTH-1:0] main_alu;
   logic [WIDTH-1:0] main_sd;
   logic [RD_W-1:0]  main_rd;
   logic             main_rw;
   logic             main_mr;
   logic             main_mw;
   logic [F3_W-1:0]  main_f3;

   assign main_v = state_q[1];
   assign skid_v = state_q[0];

   assign in_entry = {alu_result_i, store_data_i, rd_i, reg_write_i,
                      mem_read_i, mem_write_i, funct3_i};

   assign {main_alu, main_sd, main_rd, main_rw, main_mr, main_mw, main_f3} = main_q;

   // Ready depends only on the skid flop, never on mem_ready_i.
   assign ex_ready_o = ~skid_v;
   assign accept     = ex_valid_i & ex_ready_o;
   assign pop        = main_v & mem_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_d      = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               load_main_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins; data loads may still happen but become invisible.
      if (flush_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   assign mem_valid_o  = main_v;
   assign alu_result_o = main_alu;
   assign store_data_o = main_sd;
   assign rd_o         = main_rd;
   assign funct3_o     = main_f3;
   // Control bits gated so a bubble never writes architectural state.
   assign reg_write_o  = main_rw & main_v;
   assign mem_read_o   = main_mr & main_v;
   assign mem_write_o  = main_mw & main_v;

`ifdef EXMEM_FWD_EN
   assign fwd_valid_o = main_v & main_rw & ~main_mr & (main_rd != RD_W'(0));
   assign fwd_rd_o    = main_rd;
   assign fwd_data_o  = main_alu;
`endif

endmodule
